regfile_port_scheduler: RTL
===========================

Name: regfile_port_scheduler

Overview:
- Arbitrates one issue-stage read requester and two writeback requesters (wb0 = ALU, wb1 = MEM) onto the register_block ports.
- The register_block has 8 lanes x 64 regs x 32 bits, 16 warps, two read ports, one write port, and a single shared warp_selector.
- Per cycle it grants at most one write and one read, and only when both target the same warp.
- It registers the RF control signals, prevents same-cycle read/write address collisions, and bounds read starvation.

Parameters:
- LANES, 8, number of lanes (width of the enable masks)
- DATA_W, 32, data bits per lane
- ADDR_W, 6, register address width (64 regs)
- WARP_W, 4, warp id width (16 warps)
- STARVE_LIMIT, 4, consecutive denied read cycles before reads take priority

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted (combinational)
- rd_warp  in  WARP_W  warp of read
- rd_addr0, rd_addr1  in  ADDR_W  operand addresses
- rd_src_en  in  2  bit i enables operand i
- rd_mask  in  LANES  lane mask applied to both operands
- wbN_valid  in  1  write request valid, N=0,1
- wbN_ready  out  1  write request accepted (combinational), N=0,1
- wbN_warp  in  WARP_W  warp of write, N=0,1
- wbN_addr  in  ADDR_W  write address, N=0,1
- wbN_mask  in  LANES  lane write mask, N=0,1
- wbN_data  in  LANES*DATA_W  packed data, lane 0 in LSBs, N=0,1
- read_en_0, read_en_1  out  LANES  to RF
- raddr_0, raddr_1  out  ADDR_W  to RF
- write_en  out  LANES  to RF
- waddr  out  ADDR_W  to RF
- wdata  out  LANES*DATA_W  to RF, unpacked by the parent into wdata_0..7
- warp_selector  out  WARP_W  to RF
- rd_rsp_valid  out  1  RF rdata valid this cycle
- rd_rsp_warp  out  WARP_W  warp of the response
- conflict_cnt  out  16  saturating count of cycles in which a request stalled due to warp mismatch or address collision

Behaviour:
- Two stages:
  - S0: combinational arbitration on the request inputs.
  - S1: the accepted requests are registered into the RF control outputs.
- Write commits at the posedge ending S1.
- RF read is combinational, so read data is valid during S1.
- Read latency is 1 cycle from handshake: rd_rsp_valid=1 in the cycle after rd_valid&rd_ready.
- Write arbitration:
  - Round-robin between wb0 and wb1 via a 1-bit last-grant pointer; reset value selects wb0 first.
  - The pointer toggles only on an accepted write.
  - A lone valid source always wins (subject to the compatibility rules below).
- Compatibility: read W and write X may be granted together only if:
  - warp(W) == warp(X), and
  - no enabled read operand address equals waddr(X) (the same-cycle collision would return stale data).
- Priority when incompatible:
  - Writes win by default.
  - If rd_wait_cnt == STARVE_LIMIT, the read wins and all writes stall that cycle.
- rd_wait_cnt:
  - Increments each cycle rd_valid & !rd_ready, saturating at STARVE_LIMIT.
  - Clears on read accept, or when rd_valid=0.
- Read/write ordering:
  - A read accepted in the cycle a write sits in S1 executes after that write commits and sees new data.
  - No bypass is needed.
- S1 register updates on each posedge:
  - read_en_0 = rd_mask if rd_src_en[0] & read accepted, else 0.
  - read_en_1 = rd_mask if rd_src_en[1] & read accepted, else 0.
  - write_en = granted mask, else 0.
  - raddr_*, waddr, and wdata load only on grant; otherwise hold.
  - warp_selector loads the granted warp (read or write) and holds when idle.
- rd_src_en=0 with rd_valid: accepted normally; read enables are 0 but rd_rsp_valid still pulses.
- Zero masks are legal and are accepted as no-ops.
- conflict_cnt:
  - +1 in any cycle a valid request is stalled by a warp mismatch or address collision.
  - Saturates at 16'hFFFF.
- Reset (synchronous, rst=1 at posedge):
  - All enables, rd_rsp_valid, rd_wait_cnt, conflict_cnt, and the RR pointer go to 0.
  - Addresses, wdata, and warp_selector go to 0.
  - All ready outputs = 0 while rst=1.
  - An S1 write present in the reset cycle still reaches the RF at that edge; the outputs are not gated.

Test Plan:
- Write/read, warp 3: after reset, wb0 writes warp 3, addr 6'h05, mask 8'hFF, data lane i = 32'hA0+i. Next cycle, read warp 3 with addr0=addr1=5 → rd_rsp_valid the following cycle; all 16 rdata equal 32'hA0+i.
- Round-robin: wb0 and wb1 continuously valid, both warp 0 → grants alternate wb0, wb1, wb0...; write_en=8'hFF every cycle; RR starts at wb0 after reset.
- Warp mismatch: read warp 1 and wb0 warp 2 both valid → wb0 granted, read stalled. With wb0 held valid on warp 2, the read is granted on the 5th cycle (rd_wait_cnt reaches 4) and wb0 stalls that cycle. conflict_cnt increments every stalled cycle.
- Address collision: read warp 0 addr0=7 with write warp 0 addr 7 in the same cycle → only the write is granted. The read is granted the next cycle and returns the new data.
- Reset mid-stream: assert rst during continuous traffic → the next cycle all enables are 0, ready outputs are 0, and conflict_cnt = 0. After release, the first write goes to wb0.
- Sweep: all 16 warps x 64 regs, random data written via alternating wb0/wb1, then read back on both ports → zero mismatches.

Source files
------------

// File: rtl/regfile_port_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_port_scheduler
//
// Purpose:
//   Arbitrates one issue-stage read requester and two writeback requesters
//   (wb0 = ALU, wb1 = MEM) onto a register block that has two read ports, one
//   write port and a single warp selector shared by all ports. At most one
//   write and one read are granted per cycle, and they are granted together
//   only when they target the same warp and the read does not touch the
//   register being written.
//
//   S0 : combinational arbitration on the request inputs (ready outputs).
//   S1 : accepted requests are registered onto the RF control outputs.
//   The RF reads combinationally during S1, and writes commit at the edge
//   that ends S1.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rd_*                      read request (valid/ready, warp, two operand
//                             addresses, operand enables, lane mask)
//   wb0_*, wb1_*              write requests (valid/ready, warp, address,
//                             lane mask, packed lane data, lane 0 in LSBs)
//   read_en_0/1, raddr_0/1    RF read port controls
//   write_en, waddr, wdata    RF write port controls
//   warp_selector             warp shared by all RF ports
//   rd_rsp_valid, rd_rsp_warp RF read data is valid this cycle, and its warp
//   conflict_cnt              saturating count of warp/address conflict stalls
// ---------------------------------------------------------------------------
module regfile_port_scheduler #(
  parameter int LANES        = 8,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 6,
  parameter int WARP_W       = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // read request
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [WARP_W-1:0]         rd_warp,
  input  logic [ADDR_W-1:0]         rd_addr0,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [1:0]                rd_src_en,
  input  logic [LANES-1:0]          rd_mask,
  // writeback 0 (ALU)
  input  logic                      wb0_valid,
  output logic                      wb0_ready,
  input  logic [WARP_W-1:0]         wb0_warp,
  input  logic [ADDR_W-1:0]         wb0_addr,
  input  logic [LANES-1:0]          wb0_mask,
  input  logic [LANES*DATA_W-1:0]   wb0_data,
  // writeback 1 (MEM)
  input  logic                      wb1_valid,
  output logic                      wb1_ready,
  input  logic [WARP_W-1:0]         wb1_warp,
  input  logic [ADDR_W-1:0]         wb1_addr,
  input  logic [LANES-1:0]          wb1_mask,
  input  logic [LANES*DATA_W-1:0]   wb1_data,
  // register block controls
  output logic [LANES-1:0]          read_en_0,
  output logic [LANES-1:0]          read_en_1,
  output logic [ADDR_W-1:0]         raddr_0,
  output logic [ADDR_W-1:0]         raddr_1,
  output logic [LANES-1:0]          write_en,
  output logic [ADDR_W-1:0]         waddr,
  output logic [LANES*DATA_W-1:0]   wdata,
  output logic [WARP_W-1:0]         warp_selector,
  // read response / status
  output logic                      rd_rsp_valid,
  output logic [WARP_W-1:0]         rd_rsp_warp,
  output logic [15:0]               conflict_cnt
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  // S1 registers
  logic [LANES-1:0]        r_read_en_0;
  logic [LANES-1:0]        r_read_en_1;
  logic [ADDR_W-1:0]       r_raddr_0;
  logic [ADDR_W-1:0]       r_raddr_1;
  logic [LANES-1:0]        r_write_en;
  logic [ADDR_W-1:0]       r_waddr;
  logic [LANES*DATA_W-1:0] r_wdata;
  logic [WARP_W-1:0]       r_warp_sel;
  logic                    r_rd_rsp_valid;
  logic [WARP_W-1:0]       r_rd_rsp_warp;
  logic [15:0]             r_conflict_cnt;
  // arbitration state
  logic                    r_rr;           // 0: wb0 preferred, 1: wb1 preferred
  logic [WAIT_W-1:0]       r_rd_wait_cnt;

  // S0 arbitration
  logic                    w_wr_sel1;
  logic                    w_wr_valid;
  logic [WARP_W-1:0]       w_wr_warp;
  logic [ADDR_W-1:0]       w_wr_addr;
  logic [LANES-1:0]        w_wr_mask;
  logic [LANES*DATA_W-1:0] w_wr_data;
  logic                    w_collide;
  logic                    w_compat;
  logic                    w_starved;
  logic                    w_rd_grant;
  logic                    w_wr_grant;
  logic                    w_conflict;

  // Pick the write candidate first: the round-robin pointer only matters
  // when both sources are valid, otherwise the lone valid source is taken.
  always_comb begin
    w_wr_sel1 = 1'b0;
    if (wb0_valid && wb1_valid) begin
      w_wr_sel1 = r_rr;
    end else begin
      w_wr_sel1 = wb1_valid;
    end
  end

  assign w_wr_valid = wb0_valid | wb1_valid;
  assign w_wr_warp  = w_wr_sel1 ? wb1_warp : wb0_warp;
  assign w_wr_addr  = w_wr_sel1 ? wb1_addr : wb0_addr;
  assign w_wr_mask  = w_wr_sel1 ? wb1_mask : wb0_mask;
  assign w_wr_data  = w_wr_sel1 ? wb1_data : wb0_data;

  // A read and a write issued together land in S1 together; the RF read
  // happens before the write commits, so an enabled operand on the written
  // register would return stale data. Such pairs are serialised instead.
  assign w_collide = (rd_src_en[0] && (rd_addr0 == w_wr_addr)) ||
                     (rd_src_en[1] && (rd_addr1 == w_wr_addr));
  assign w_compat  = (rd_warp == w_wr_warp) && !w_collide;
  assign w_starved = (r_rd_wait_cnt == WAIT_W'(STARVE_LIMIT));

  // Writes win an incompatible pair unless the read has been starved.
  assign w_rd_grant = !rst && rd_valid   && (!w_wr_valid || w_compat ||  w_starved);
  assign w_wr_grant = !rst && w_wr_valid && (!rd_valid   || w_compat || !w_starved);
  assign w_conflict = !rst && rd_valid && w_wr_valid && !w_compat;

  assign rd_ready  = w_rd_grant;
  assign wb0_ready = w_wr_grant && !w_wr_sel1;
  assign wb1_ready = w_wr_grant &&  w_wr_sel1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_en_0    <= '0;
      r_read_en_1    <= '0;
      r_raddr_0      <= '0;
      r_raddr_1      <= '0;
      r_write_en     <= '0;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_warp_sel     <= '0;
      r_rd_rsp_valid <= 1'b0;
      r_rd_rsp_warp  <= '0;
      r_conflict_cnt <= '0;
      r_rr           <= 1'b0;
      r_rd_wait_cnt  <= '0;
    end else begin
      r_read_en_0    <= (w_rd_grant && rd_src_en[0]) ? rd_mask : '0;
      r_read_en_1    <= (w_rd_grant && rd_src_en[1]) ? rd_mask : '0;
      r_write_en     <= w_wr_grant ? w_wr_mask : '0;
      r_rd_rsp_valid <= w_rd_grant;

      if (w_rd_grant) begin
        r_raddr_0     <= rd_addr0;
        r_raddr_1     <= rd_addr1;
        r_rd_rsp_warp <= rd_warp;
        r_warp_sel    <= rd_warp;
      end

      // When both are granted the warps are equal, so the order of these
      // two warp selector loads does not matter.
      if (w_wr_grant) begin
        r_waddr    <= w_wr_addr;
        r_wdata    <= w_wr_data;
        r_warp_sel <= w_wr_warp;
        r_rr       <= ~r_rr;
      end

      if (!rd_valid || w_rd_grant) begin
        r_rd_wait_cnt <= '0;
      end else if (!w_starved) begin
        r_rd_wait_cnt <= r_rd_wait_cnt + WAIT_W'(1);
      end

      if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  assign read_en_0     = r_read_en_0;
  assign read_en_1     = r_read_en_1;
  assign raddr_0       = r_raddr_0;
  assign raddr_1       = r_raddr_1;
  assign write_en      = r_write_en;
  assign waddr         = r_waddr;
  assign wdata         = r_wdata;
  assign warp_selector = r_warp_sel;
  assign rd_rsp_valid  = r_rd_rsp_valid;
  assign rd_rsp_warp   = r_rd_rsp_warp;
  assign conflict_cnt  = r_conflict_cnt;

endmodule
